multi_channel_up_down_counter: RTL and testbench
================================================

// Module: multi_channel_up_down_counter
// PURPOSE
//  Parametrised N-channel up/down occupancy counter for the AXI slave response path.
//  Each channel tracks outstanding entries for one response buffer or ID group.
//  Per-cycle increment and decrement steps can each be larger than 1.
//  Each channel saturates at MAX_COUNT and at 0, and raises sticky error flags.
//  Registered full, empty and almost-full/empty flags feed the push FSM backpressure logic.
// PARAMETERS
//  NUM_CH      4    number of independent channels (>=1)
//  MAX_COUNT   10   upper saturation value of every channel (>=1)
//  STEP_W      2    width of up_amt/down_amt; maximum step is 2**STEP_W-1
//  AF_THRESH   8    almost_full asserts when count >= AF_THRESH
//  AE_THRESH   2    almost_empty asserts when count <= AE_THRESH
//  CNT_W       $clog2(MAX_COUNT+1)  derived localparam, not overridable
// PORTS
//  clk           in   1              single clock, rising edge
//  rst           in   1              synchronous reset, active-high
//  up_en         in   NUM_CH         per-channel increment request
//  up_amt        in   NUM_CH*STEP_W  per-channel increment amount; channel c in [c*STEP_W +: STEP_W]
//  down_en       in   NUM_CH         per-channel decrement request
//  down_amt      in   NUM_CH*STEP_W  per-channel decrement amount; same packing as up_amt
//  clr           in   NUM_CH         per-channel clear of count and sticky errors
//  count         out  NUM_CH*CNT_W   current count per channel; packed like up_amt
//  full          out  NUM_CH         count == MAX_COUNT
//  empty         out  NUM_CH         count == 0
//  almost_full   out  NUM_CH         count >= AF_THRESH
//  almost_empty  out  NUM_CH         count <= AE_THRESH
//  err_ovf       out  NUM_CH         sticky: a request tried to exceed MAX_COUNT
//  err_udf       out  NUM_CH         sticky: a request tried to go below 0
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge):
//    - all counts 0; empty=1, almost_empty=1; full, almost_full, err_ovf, err_udf = 0.
//    - rst overrides every other input.
//    - Asserting rst mid-operation discards that cycle's requests.
//  - Channels are fully independent. No cross-channel arbitration.
//  - Latency is 1 cycle. Requests sampled at edge k appear on count and flags after edge k.
//    All outputs are registered. No combinational path from inputs to outputs.
//  - Effective step:
//    - inc = up_en ? up_amt : 0
//    - dec = down_en ? down_amt : 0
//    - An enable with amt=0 is a no-op and never raises an error.
//  - Arithmetic:
//    - nxt = count + inc - dec, computed signed at width CNT_W+STEP_W+1. No intermediate wrap.
//    - Simultaneous up and down are netted in the same cycle. Example: count 10, +2 -3 -> 9, no error.
//  - Saturation:
//    - nxt > MAX_COUNT -> count = MAX_COUNT and err_ovf set.
//    - nxt < 0 -> count = 0 and err_udf set.
//    - The count never wraps around.
//  - clr[c]:
//    - Takes precedence over up/down on channel c.
//    - Sets count to 0 and clears err_ovf and err_udf.
//    - Requests on the same cycle are dropped.
//  - Flags are decoded from the next count and registered, so they are always consistent with count.
//  - err_* stay set until clr[c] or rst. They are independent of later valid traffic.
//  - Parameter legality is checked at elaboration with $error:
//    AE_THRESH < AF_THRESH <= MAX_COUNT, and 2**STEP_W-1 <= MAX_COUNT.
// STRUCTURE
//  - Shared package up_down_counter_pkg holds:
//    - function cnt_width(max) returning $clog2(max+1);
//    - typedef struct packed {full, empty, almost_full, almost_empty, err_ovf, err_udf} cnt_flags_t.
//  - Sub-module up_down_counter_ch is one channel: count register, net/saturate logic, flag registers.
//  - The top is a generate-for over NUM_CH instances plus packing and unpacking of the vector ports.
// TESTING
//  1. rst held 3 cycles, then released -> all counts 0, empty=1, almost_empty=1, other flags 0.
//  2. ch0 up_en, amt=1, for 10 cycles (MAX_COUNT=10):
//     - count steps 1..10, one step per cycle;
//     - almost_full from count 8; full at 10; err_ovf=0.
//     - One more +1 -> count stays 10, err_ovf=1.
//  3. ch1 at 1, down_amt=3 -> count 0, err_udf=1, empty=1.
//     Then clr[1] -> err_udf=0, count 0.
//  4. ch2 at 5, up_amt=2 and down_amt=3 in the same cycle -> count 4.
//     At 10: +3 and -3 together -> count 10, no error.
//  5. All channels driven with different random steps at once:
//     - each count matches an independent reference model;
//     - traffic on ch3 never disturbs ch0.
//  6. ch0 at 7 with up_en active, rst asserted that cycle -> count 0, no error.
//     clr together with up_en -> count 0 and the increment is dropped.

Source files
------------

// File: rtl/up_down_counter_pkg.sv
// Shared types and helpers for the multi-channel occupancy counter.
// Holds the count-width helper and the per-channel flag bundle.
package up_down_counter_pkg;

   function automatic int cnt_width(input int max);
      return $clog2(max + 1);
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic err_ovf;
      logic err_udf;
   } cnt_flags_t;

endpackage

// File: rtl/up_down_counter_ch.sv
// One occupancy channel: nets up/down steps, saturates at 0 and MAX_COUNT,
// and registers count plus flags decoded from the next count.
module up_down_counter_ch
   import up_down_counter_pkg::*;
#(
   parameter int MAX_COUNT = 10,
   parameter int STEP_W    = 2,
   parameter int AF_THRESH = 8,
   parameter int AE_THRESH = 2,
   localparam int CNT_W    = cnt_width(MAX_COUNT)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              up_en_i,
   input  logic [STEP_W-1:0] up_amt_i,
   input  logic              down_en_i,
   input  logic [STEP_W-1:0] down_amt_i,
   input  logic              clr_i,
   output logic [CNT_W-1:0]  count_o,
   output cnt_flags_t        flags_o
);

   localparam int NW = CNT_W + STEP_W + 1;
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);
   localparam logic [CNT_W-1:0] AF_C  = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AE_C  = CNT_W'(AE_THRESH);
   localparam logic signed [NW-1:0] MAX_S = NW'(MAX_COUNT);

   logic [CNT_W-1:0]     count_q, count_d;
   cnt_flags_t           flags_q, flags_d;
   logic [STEP_W-1:0]    inc, dec;
   logic signed [NW-1:0] nxt;
   logic                 ovf_d, udf_d;

   // Net the step, saturate, and decode flags from the next count.
   always_comb begin
      inc     = up_en_i   ? up_amt_i   : '0;
      dec     = down_en_i ? down_amt_i : '0;
      nxt     = signed'(NW'(count_q)) + signed'(NW'(inc))
              - signed'(NW'(dec));
      count_d = count_q;
      ovf_d   = flags_q.err_ovf;
      udf_d   = flags_q.err_udf;
      if (clr_i) begin
         count_d = '0;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end else if (nxt > MAX_S) begin
         count_d = MAX_C;
         ovf_d   = 1'b1;
      end else if (nxt < 0) begin
         count_d = '0;
         udf_d   = 1'b1;
      end else begin
         count_d = nxt[CNT_W-1:0];
      end
      flags_d.full         = (count_d == MAX_C);
      flags_d.empty        = (count_d == '0);
      flags_d.almost_full  = (count_d >= AF_C);
      flags_d.almost_empty = (count_d <= AE_C);
      flags_d.err_ovf      = ovf_d;
      flags_d.err_udf      = udf_d;
   end

   // Count and flag registers; reset leaves the channel empty.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         flags_q <= '{full: 1'b0, empty: 1'b1,
                      almost_full: 1'b0, almost_empty: 1'b1,
                      err_ovf: 1'b0, err_udf: 1'b0};
      end else begin
         count_q <= count_d;
         flags_q <= flags_d;
      end
   end

   assign count_o = count_q;
   assign flags_o = flags_q;

endmodule

// File: rtl/multi_channel_up_down_counter.sv
// N independent occupancy channels for the AXI slave response path.
// Unpacks the vector ports per channel and repacks the registered results.
module multi_channel_up_down_counter
   import up_down_counter_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int MAX_COUNT = 10,
   parameter int STEP_W    = 2,
   parameter int AF_THRESH = 8,
   parameter int AE_THRESH = 2,
   localparam int CNT_W    = cnt_width(MAX_COUNT)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        up_en,
   input  logic [NUM_CH*STEP_W-1:0] up_amt,
   input  logic [NUM_CH-1:0]        down_en,
   input  logic [NUM_CH*STEP_W-1:0] down_amt,
   input  logic [NUM_CH-1:0]        clr,
   output logic [NUM_CH*CNT_W-1:0]  count,
   output logic [NUM_CH-1:0]        full,
   output logic [NUM_CH-1:0]        empty,
   output logic [NUM_CH-1:0]        almost_full,
   output logic [NUM_CH-1:0]        almost_empty,
   output logic [NUM_CH-1:0]        err_ovf,
   output logic [NUM_CH-1:0]        err_udf
);

   if (!(AE_THRESH < AF_THRESH && AF_THRESH <= MAX_COUNT
         && (2**STEP_W) - 1 <= MAX_COUNT && NUM_CH >= 1)) begin : g_bad
      $error("multi_channel_up_down_counter: illegal parameters");
   end

   cnt_flags_t flags [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      up_down_counter_ch #(
         .MAX_COUNT (MAX_COUNT),
         .STEP_W    (STEP_W),
         .AF_THRESH (AF_THRESH),
         .AE_THRESH (AE_THRESH)
      ) u_ch (
         .clk_i      (clk),
         .rst_i      (rst),
         .up_en_i    (up_en[g]),
         .up_amt_i   (up_amt[g*STEP_W +: STEP_W]),
         .down_en_i  (down_en[g]),
         .down_amt_i (down_amt[g*STEP_W +: STEP_W]),
         .clr_i      (clr[g]),
         .count_o    (count[g*CNT_W +: CNT_W]),
         .flags_o    (flags[g])
      );

      assign full[g]         = flags[g].full;
      assign empty[g]        = flags[g].empty;
      assign almost_full[g]  = flags[g].almost_full;
      assign almost_empty[g] = flags[g].almost_empty;
      assign err_ovf[g]      = flags[g].err_ovf;
      assign err_udf[g]      = flags[g].err_udf;
   end

endmodule

// File: tb/tb_multi_channel_up_down_counter.sv
// Directed and random checks of the multi-channel occupancy counter
// against an integer reference model of each channel.
module tb_multi_channel_up_down_counter;

   localparam int NUM_CH = 4;
   localparam int MAX    = 10;
   localparam int STEP_W = 2;
   localparam int AF     = 8;
   localparam int AE     = 2;
   localparam int CNT_W  = 4;

   logic clk = 1'b0;
   logic rst;
   logic [NUM_CH-1:0]        up_en, down_en, clr;
   logic [NUM_CH*STEP_W-1:0] up_amt, down_amt;
   logic [NUM_CH*CNT_W-1:0]  count;
   logic [NUM_CH-1:0]        full, empty, almost_full, almost_empty;
   logic [NUM_CH-1:0]        err_ovf, err_udf;

   int checks = 0;
   int errors = 0;
   int m_cnt [NUM_CH];
   bit m_ovf [NUM_CH];
   bit m_udf [NUM_CH];

   multi_channel_up_down_counter #(
      .NUM_CH    (NUM_CH),
      .MAX_COUNT (MAX),
      .STEP_W    (STEP_W),
      .AF_THRESH (AF),
      .AE_THRESH (AE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .up_en        (up_en),
      .up_amt       (up_amt),
      .down_en      (down_en),
      .down_amt     (down_amt),
      .clr          (clr),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .err_ovf      (err_ovf),
      .err_udf      (err_udf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int cnt_of(input int c);
      return int'(count[c*CNT_W +: CNT_W]);
   endfunction

   task automatic model_step();
      int nxt;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rst || clr[c]) begin
            m_cnt[c] = 0;
            m_ovf[c] = 0;
            m_udf[c] = 0;
         end else begin
            nxt = m_cnt[c];
            if (up_en[c])   nxt += int'(up_amt[c*STEP_W +: STEP_W]);
            if (down_en[c]) nxt -= int'(down_amt[c*STEP_W +: STEP_W]);
            if (nxt > MAX) begin
               m_cnt[c] = MAX;
               m_ovf[c] = 1;
            end else if (nxt < 0) begin
               m_cnt[c] = 0;
               m_udf[c] = 1;
            end else begin
               m_cnt[c] = nxt;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < NUM_CH; c++) begin
         chk($sformatf("count[%0d]", c), cnt_of(c), m_cnt[c]);
         chk($sformatf("full[%0d]", c), full[c], m_cnt[c] == MAX);
         chk($sformatf("empty[%0d]", c), empty[c], m_cnt[c] == 0);
         chk($sformatf("afull[%0d]", c), almost_full[c], m_cnt[c] >= AF);
         chk($sformatf("aempty[%0d]", c), almost_empty[c], m_cnt[c] <= AE);
         chk($sformatf("ovf[%0d]", c), err_ovf[c], m_ovf[c]);
         chk($sformatf("udf[%0d]", c), err_udf[c], m_udf[c]);
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      up_en = '0; down_en = '0; clr = '0;
      up_amt = '0; down_amt = '0;
   endtask

   task automatic set_up(input int c, input int a);
      up_en[c] = 1'b1;
      up_amt[c*STEP_W +: STEP_W] = STEP_W'(a);
   endtask

   task automatic set_dn(input int c, input int a);
      down_en[c] = 1'b1;
      down_amt[c*STEP_W +: STEP_W] = STEP_W'(a);
   endtask

   initial begin
      int saved;
      rst = 1'b1;
      idle();
      foreach (m_cnt[c]) begin
         m_cnt[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
      end

      // 1. reset held three cycles, then released
      repeat (3) cycle();
      rst = 1'b0;
      cycle();
      chk("rst_empty", empty, 4'b1111);
      chk("rst_aempty", almost_empty, 4'b1111);
      chk("rst_full", full, 4'b0000);

      // 2. ch0 counts up to saturation
      set_up(0, 1);
      for (int i = 1; i <= MAX; i++) begin
         cycle();
         chk("ch0_step", cnt_of(0), i);
         chk("ch0_afull", almost_full[0], i >= 8);
      end
      chk("ch0_full", full[0], 1'b1);
      chk("ch0_noovf", err_ovf[0], 1'b0);
      cycle();
      chk("ch0_sat", cnt_of(0), MAX);
      chk("ch0_ovf", err_ovf[0], 1'b1);
      idle();

      // 3. ch1 underflow then clear
      set_up(1, 1);
      cycle();
      idle();
      set_dn(1, 3);
      cycle();
      chk("ch1_udf_cnt", cnt_of(1), 0);
      chk("ch1_udf", err_udf[1], 1'b1);
      chk("ch1_empty", empty[1], 1'b1);
      idle();
      cycle();
      chk("ch1_sticky", err_udf[1], 1'b1);
      clr[1] = 1'b1;
      cycle();
      chk("ch1_clr_udf", err_udf[1], 1'b0);
      chk("ch1_clr_cnt", cnt_of(1), 0);
      idle();

      // 4. ch2 netting of simultaneous up and down
      set_up(2, 3); cycle();
      set_up(2, 2); cycle();
      chk("ch2_at5", cnt_of(2), 5);
      set_up(2, 2); set_dn(2, 3); cycle();
      chk("ch2_net", cnt_of(2), 4);
      idle();
      set_up(2, 3); cycle(); cycle();
      chk("ch2_at10", cnt_of(2), 10);
      set_dn(2, 3); cycle();
      chk("ch2_net_top", cnt_of(2), 10);
      chk("ch2_noovf", err_ovf[2], 1'b0);
      idle();

      // 5. random traffic on every channel
      for (int n = 0; n < 300; n++) begin
         up_en    = NUM_CH'($urandom);
         down_en  = NUM_CH'($urandom);
         up_amt   = (NUM_CH*STEP_W)'($urandom);
         down_amt = (NUM_CH*STEP_W)'($urandom);
         for (int c = 0; c < NUM_CH; c++)
            clr[c] = ($urandom_range(0, 15) == 0);
         cycle();
      end
      idle();
      saved = m_cnt[0];
      for (int n = 0; n < 40; n++) begin
         up_en[3]    = 1'($urandom);
         down_en[3]  = 1'($urandom);
         up_amt[3*STEP_W +: STEP_W]   = STEP_W'($urandom);
         down_amt[3*STEP_W +: STEP_W] = STEP_W'($urandom);
         cycle();
         chk("ch0_isolated", cnt_of(0), saved);
      end
      idle();

      // 6. reset and clear each drop a concurrent increment
      clr = '1; cycle(); idle();
      set_up(0, 3); cycle(); cycle();
      set_up(0, 1); cycle();
      chk("ch0_at7", cnt_of(0), 7);
      set_up(0, 2);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_drop_cnt", cnt_of(0), 0);
      chk("rst_drop_ovf", err_ovf[0], 1'b0);
      idle();
      set_up(0, 2); cycle();
      clr[0] = 1'b1;
      set_up(0, 3);
      cycle();
      chk("clr_drop_cnt", cnt_of(0), 0);
      idle();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
